// File: rtl/dmem_responder.sv
// Zero-latency data-memory responder: word RAM plus an optional MMIO block.
// Optional MMIO region (CYCLE, LED, STATUS, STORES) is built when DMEM_MMIO_EN is defined.
`timescale 1ns/1ps
module dmem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter logic [31:0] MMIO_BASE = 32'h1002_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_r,
  input  logic        dmem_w,
  input  logic [31:0] data_addr,
  input  logic [31:0] w_data,
  output logic [31:0] dmem_data,
  output logic [15:0] led,
  output logic        err
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);

  logic [31:0]   r_mem [DEPTH];
  logic          r_err;
  logic [31:0]   w_ram_off;
  logic [AW-1:0] w_ram_idx;
  logic          w_ram_hit;
  logic          w_mmio_hit;
  logic [31:0]   w_mmio_rdata;
  logic          w_err_clr;
  logic          w_access;
  logic          w_valid;
  logic          w_bad;
  logic          w_ram_we;

  assign w_ram_off = data_addr - BASE_ADDR;
  assign w_ram_hit = (data_addr >= BASE_ADDR) && (w_ram_off < RAM_BYTES);
  assign w_ram_idx = w_ram_off[AW+1:2];

  assign w_access = dmem_r | dmem_w;
  assign w_valid  = (data_addr[1:0] == 2'b00) && (w_ram_hit || w_mmio_hit);
  assign w_bad    = w_access && !w_valid;
  assign w_ram_we = dmem_w && w_valid && w_ram_hit;

  assign dmem_data = (dmem_r && w_valid) ? (w_ram_hit ? r_mem[w_ram_idx] : w_mmio_rdata)
                                         : 32'h0;

  // RAM is not reset; stores are suppressed while reset is held
  always_ff @(posedge clk) begin
    if (rst && w_ram_we) begin
      r_mem[w_ram_idx] <= w_data;
    end
  end

`ifdef DMEM_MMIO_EN
  logic [31:0] w_mmio_off;
  logic [1:0]  w_mmio_sel;
  logic        w_mmio_we;
  logic [31:0] r_cycle;
  logic [31:0] r_stores;
  logic [15:0] r_led;

  assign w_mmio_off = data_addr - MMIO_BASE;
  assign w_mmio_hit = (data_addr >= MMIO_BASE) && (w_mmio_off < 32'd16);
  assign w_mmio_sel = w_mmio_off[3:2];
  assign w_mmio_we  = dmem_w && w_valid && w_mmio_hit;
  assign w_err_clr  = w_mmio_we && (w_mmio_sel == 2'd2) && w_data[0];

  always_comb begin
    w_mmio_rdata = 32'h0;
    case (w_mmio_sel)
      2'd0:    w_mmio_rdata = r_cycle;
      2'd1:    w_mmio_rdata = {16'h0, r_led};
      2'd2:    w_mmio_rdata = {31'h0, r_err};
      default: w_mmio_rdata = r_stores;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle  <= 32'h0;
      r_stores <= 32'h0;
      r_led    <= 16'h0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_ram_we) begin
        r_stores <= r_stores + 32'd1;
      end
      if (w_mmio_we && (w_mmio_sel == 2'd1)) begin
        r_led <= w_data[15:0];
      end
    end
  end

  assign led = r_led;
`else
  assign w_mmio_hit   = 1'b0;
  assign w_mmio_rdata = 32'h0;
  assign w_err_clr    = 1'b0;
  assign led          = 16'h0;
`endif

  // Sticky error: a bad access in the same cycle beats a clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_bad) begin
      r_err <= 1'b1;
    end else if (w_err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign err = r_err;

endmodule
